// File: rtl/barrett_pkg.sv
// barrett_pkg: shared widths, state encoding and vector types for the Barrett setup and reduction blocks
package barrett_pkg;
    localparam int Q_W  = 64;
    localparam int K_W  = 8;
    localparam int MU_W = Q_W + 2;
    typedef enum logic [1:0] {IDLE, NORM, DIV, DONE} bmu_state_t;
    typedef logic [Q_W-1:0]  q_t;
    typedef logic [MU_W-1:0] mu_t;
    typedef logic [K_W-1:0]  k_t;
endpackage

// File: rtl/msb_index_enc.sv
// msb_index_enc: combinational priority encoder returning the position of the highest set bit
//   din  in   Q_W  value to encode
//   idx  out  K_W  index of the MSB of din; 0 when din is 0
module msb_index_enc #(
    parameter int Q_W = 64,
    parameter int K_W = 8
) (
    input  logic [Q_W-1:0] din,
    output logic [K_W-1:0] idx
);
    always_comb begin
        idx = '0;
        for (int i = 0; i < Q_W; i++)
            if (din[i]) idx = K_W'(i);
    end
endmodule

// File: rtl/barrett_mu_precompute.sv
// barrett_mu_precompute: computes k = bitlen(q) and mu = floor(2^(2k)/q) with a bit-serial restoring divider
//   clk, rst   clock (rising edge), asynchronous active-low reset
//   start, q   run request sampled in IDLE; q captured on the accepted start edge
//   busy       high from the accepted start until done
//   done       one-cycle pulse; mu, k, err valid from this cycle until the next accepted start
//   err        q < 2
//   mu, k      Barrett constants
module barrett_mu_precompute
    import barrett_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  q_t   q,
    output logic busy,
    output logic done,
    output logic err,
    output mu_t  mu,
    output k_t   k
);
    bmu_state_t   state_q, state_d;
    q_t           q_r_q, q_r_d, rem_q, rem_d;
    k_t           k_r_q, k_r_d, k_q, k_d, idx;
    logic [K_W:0] cnt_q, cnt_d;
    mu_t          quo_q, quo_d, mu_q, mu_d;
    logic         busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [Q_W:0] rem_sh;
    logic         ge, lt2;

    msb_index_enc #(.Q_W(Q_W), .K_W(K_W)) u_enc (.din(q_r_q), .idx(idx));

    assign lt2 = q_r_q[Q_W-1:1] == '0;

    // The dividend's single 1 is fed only while cnt still holds its load value 2k+1.
    // The remainder is always < q after a step, so Q_W bits hold it; the shifted
    // value needs Q_W+1 bits for the compare/subtract.
    // For q < 2 k_r is 0, so cnt loads 1 and a single dummy DIV cycle gives the
    // error path the same 2k+3 latency formula; its quotient is discarded.
    always_comb begin
        state_d = state_q;
        q_r_d   = q_r_q;
        k_r_d   = k_r_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        mu_d    = mu_q;
        k_d     = k_q;
        rem_sh  = {rem_q, cnt_q == {k_r_q, 1'b1}};
        ge      = rem_sh >= {1'b0, q_r_q};
        case (state_q)
            IDLE: if (start) begin
                state_d = NORM;
                q_r_d   = q;
                rem_d   = '0;
                quo_d   = '0;
                busy_d  = 1'b1;
                err_d   = 1'b0;
                mu_d    = '0;
                k_d     = '0;
            end
            NORM: begin
                k_r_d   = lt2 ? '0 : idx + K_W'(1);
                err_d   = lt2;
                cnt_d   = {k_r_d, 1'b1};
                state_d = DIV;
            end
            DIV: begin
                rem_d   = Q_W'(ge ? rem_sh - {1'b0, q_r_q} : rem_sh);
                quo_d   = {quo_q[MU_W-2:0], ge};
                cnt_d   = cnt_q - (K_W+1)'(1);
                state_d = cnt_q == (K_W+1)'(1) ? DONE : DIV;
            end
            DONE: begin
                mu_d    = err_q ? '0 : quo_q;
                k_d     = k_r_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            q_r_q   <= '0;
            k_r_q   <= '0;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            mu_q    <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            q_r_q   <= q_r_d;
            k_r_q   <= k_r_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            mu_q    <= mu_d;
            k_q     <= k_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;
    assign mu   = mu_q;
    assign k    = k_q;
endmodule
